// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared EX-stage op codes and divider FSM defines
package div_unit_pkg;

    localparam logic [7:0] EXE_NOP_OP  = 8'h00;
    localparam logic [7:0] EXE_AND_OP  = 8'h24;
    localparam logic [7:0] EXE_OR_OP   = 8'h25;
    localparam logic [7:0] EXE_ADD_OP  = 8'h20;
    localparam logic [7:0] EXE_SUB_OP  = 8'h22;
    localparam logic [7:0] EXE_MULT_OP = 8'h18;
    localparam logic [7:0] EXE_DIV_OP  = 8'h1a;
    localparam logic [7:0] EXE_DIVU_OP = 8'h1b;

    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_ON   = 2'b01;
    localparam logic [1:0] DIV_END  = 2'b10;
    localparam logic [1:0] DIV_ZERO = 2'b11;

    localparam int DIV_ITER = 32;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Keep the bit shifted out of rem so divisors >= 2^(WIDTH-1) stay exact.
    assign shifted  = {rem, msb};
    assign trial    = shifted - {1'b0, divisor};
    assign q_bit    = ~trial[WIDTH];
    assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle signed/unsigned divider; DIV_ZERO_FAST_EN enables 1-cycle divide-by-zero
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    input  logic               signed_div,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic             issue;
    logic             fast_zero;
    logic             num1_neg;
    logic             num2_neg;

    assign issue    = start && !annul;
    assign num1_neg = signed_div && num1[WIDTH-1];
    assign num2_neg = signed_div && num2[WIDTH-1];
    assign busy     = (state == DIV_ON) || (state == DIV_IDLE && issue);

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = (num2 == '0);
`else
    assign fast_zero = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .msb      (dvd[WIDTH-1]),
        .divisor  (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            result <= '0;
            ready  <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    ready <= 1'b0;
                    if (issue) begin
                        dvd   <= num1_neg ? -num1 : num1;
                        dsr   <= num2_neg ? -num2 : num2;
                        rem   <= '0;
                        cnt   <= '0;
                        q_neg <= num1_neg ^ num2_neg;
                        r_neg <= num1_neg;
                        if (fast_zero) begin
                            result <= {num1, {WIDTH{1'b1}}};
                            ready  <= 1'b1;
                            state  <= DIV_ZERO;
                        end else begin
                            state  <= DIV_ON;
                        end
                    end
                end
                DIV_ON: begin
                    if (annul) begin
                        state <= DIV_IDLE;
                        ready <= 1'b0;
                    end else if (cnt == CNT_W'(DIV_ITER)) begin
                        // A zero divisor leaves |num1| in rem, so undoing r_neg restores num1.
                        if (dsr == '0)
                            result <= {(r_neg ? -rem : rem), {WIDTH{1'b1}}};
                        else
                            result <= {(r_neg ? -rem : rem), (q_neg ? -dvd : dvd)};
                        ready <= 1'b1;
                        state <= DIV_END;
                    end else begin
                        rem <= rem_next;
                        dvd <= {dvd[WIDTH-2:0], q_bit};
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (annul || !start) begin
                        state <= DIV_IDLE;
                        ready <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
